data_bus_responder: RTL
=======================

DATA_BUS_RESPONDER -- requirements
Module: data_bus_responder

Interface
REQ-001 The module SHALL have a parameter DM_WORDS, default 3072, giving the number of 32-bit data-memory words (region 0x0000_0000 to 0x0000_2FFF).
REQ-002 The module SHALL have these ports:
- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- m_data_addr  input  32  byte address from the CPU memory stage.
- m_data_wdata  input  32  store data, already byte-lane aligned.
- m_data_byteen  input  4  byte-lane write enables; 4'b0000 means no write.
- m_inst_addr  input  32  PC of the instruction currently in the memory stage (logging only).
- m_data_rdata  output  32  read data for m_data_addr.
- irq  output  1  timer interrupt request, level.

Function
REQ-003 Decode SHALL be: DM for addr < 0x3000; timer for addr 0x7F00, 0x7F04 and 0x7F08; anything else unmapped.
REQ-004 m_data_rdata SHALL be combinational, valid in the same cycle as m_data_addr, using word index addr[13:2] for DM and 0 for unmapped addresses.
REQ-005 A DM write SHALL occur at the rising edge for each lane i where m_data_byteen[i]=1, writing wdata[8i+7:8i]; lanes with byteen[i]=0 keep their old value.
REQ-006 A read to the same word in the same cycle as a write SHALL return the pre-write value.
REQ-007 Writes to unmapped addresses SHALL be ignored; addr[1:0] SHALL be ignored for decode.
REQ-008 Timer registers:
- CTRL at 0x7F00, read/write: bit0 EN, bits2:1 MODE (00 one-shot, 01 auto-reload), bit3 IM; other bits read as 0.
- PRESET at 0x7F04, read/write.
- COUNT at 0x7F08, read-only.
REQ-009 A timer write SHALL take effect only when byteen=4'b1111; all other byteen values SHALL be ignored for timer addresses.
REQ-010 Timer FSM states SHALL be IDLE, LOAD, CNT and INT.
REQ-011 Timer FSM transitions SHALL be:
- IDLE to LOAD when EN=1.
- LOAD: COUNT<=PRESET, then to CNT.
- CNT: to IDLE if EN=0; else to INT if COUNT==0; else COUNT decrements by 1.
- INT to IDLE.
REQ-012 On entry to INT, irq_flag SHALL be set.
REQ-013 In MODE 00, the INT to IDLE edge SHALL clear EN, and irq_flag SHALL be held until CTRL or PRESET is written.
REQ-014 In MODE 01, irq_flag SHALL clear at the INT to IDLE edge, and EN SHALL remain set, so the counter reloads.
REQ-015 irq SHALL equal irq_flag & IM.
REQ-016 If a CPU write to CTRL and the FSM's EN-clear happen on the same edge, the CPU write value SHALL win.
REQ-017 A CPU write of EN=0 during LOAD or CNT SHALL force the FSM to IDLE on the next edge, with COUNT holding its value.
REQ-018 PRESET=0 SHALL give LOAD to CNT to INT with no decrement; COUNT SHALL never wrap below 0.

Reset
REQ-019 Reset SHALL asynchronously clear all DM words, CTRL, PRESET, COUNT and irq_flag to 0, and set the FSM to IDLE.
REQ-020 After reset, m_data_rdata SHALL be 0 for all addresses and irq SHALL be 0.
REQ-021 Reset asserted mid-count SHALL abort the count, with no irq after release.

Configuration
REQ-022 With DM_WRITE_LOG_EN defined, every DM write edge with byteen!=0 SHALL print "@<m_inst_addr hex>: *<word-aligned addr hex> <= <merged word hex>" through the simulation console.
REQ-023 Without DM_WRITE_LOG_EN, no print logic SHALL be compiled.
REQ-024 Functional behaviour SHALL be identical with and without DM_WRITE_LOG_EN.

Structure
REQ-025 Package dbus_pkg SHALL hold the region base/limit constants, the timer register offsets, the MODE encodings and the timer FSM state enum.
REQ-026 The timer SHALL be a sub-module timer_dev with a register-bus-style write/read port and an irq output.
REQ-027 DM storage and decode SHALL stay in the top module.

Verification
REQ-028 Write 0x1234_5678 to 0x0010 with byteen 1111, then byteen 0010 with wdata 0x0000_AB00 -> read of 0x0010 returns 0x1234_AB78.
REQ-029 Read and write 0x0010 in the same cycle with new data 0xFFFF_FFFF -> rdata shows the old value that cycle and 0xFFFF_FFFF the next cycle.
REQ-030 Write PRESET=3, then CTRL=0x9 (EN, one-shot, IM) at edge e0 -> LOAD at e1; COUNT=3 at e2; COUNT 2,1,0 at e3 to e5; INT and irq=1 at e6; EN=0 after e7; irq stays 1 until CTRL is written with 0.
REQ-031 CTRL=0xB (auto-reload), PRESET=2 -> irq is a 1-cycle pulse, repeating every 6 cycles.
REQ-032 Timer write with byteen 0011, and a write to 0x4000 -> no register change; reading 0x4000 returns 0.
REQ-033 Assert reset while COUNT=5 -> COUNT=0, IDLE, irq=0, DM word 0x0010 reads 0.

Source files
------------

// File: rtl/data_bus_responder_pkg.sv
// Shared definitions for the data-bus responder: address map, timer
// register offsets, timer MODE encodings, timer FSM states and a
// byte-lane merge helper.
package dbus_pkg;

  // Data-memory region: [DM_BASE, DM_LIMIT)
  localparam logic [31:0] DM_BASE  = 32'h0000_0000;
  localparam logic [31:0] DM_LIMIT = 32'h0000_3000;

  // Timer register block
  localparam logic [31:0] TMR_BASE      = 32'h0000_7F00;
  localparam logic [1:0]  TMR_OFF_CTRL  = 2'd0;  // 0x7F00
  localparam logic [1:0]  TMR_OFF_PRESET = 2'd1; // 0x7F04
  localparam logic [1:0]  TMR_OFF_COUNT = 2'd2;  // 0x7F08

  // CTRL.MODE encodings
  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_AUTO    = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } tmr_state_e;

  // Replace the byte lanes of old_w selected by be with those of new_w.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] m;
    m = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        m[8*i +: 8] = new_w[8*i +: 8];
      end else begin
        m[8*i +: 8] = old_w[8*i +: 8];
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/data_bus_responder_timer.sv
// timer_dev: down-counting timer with CTRL/PRESET/COUNT registers behind a
// simple register port. One-shot mode latches the interrupt flag until
// software rewrites CTRL or PRESET; auto-reload mode pulses it for a cycle.
module timer_dev
  import dbus_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        we_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        irq_o
);

  tmr_state_e  state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;     // {IM, MODE[1:0], EN}
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        flag_q, flag_d;
  logic        irq_q;
  logic        set_s;

  // FSM next state, counter, flag and CPU-write merge (CPU write applied last so it wins)
  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    flag_d   = flag_q;
    set_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (ctrl_q[0]) begin
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (!ctrl_q[0]) begin
          state_d = IDLE;
        end else begin
          count_d = preset_q;
          state_d = CNT;
        end
      end
      CNT: begin
        if (!ctrl_q[0]) begin
          state_d = IDLE;
        end else if (count_q == 32'd0) begin
          state_d = INT;
          flag_d  = 1'b1;
          set_s   = 1'b1;
        end else begin
          count_d = count_q - 32'd1;
        end
      end
      INT: begin
        state_d = IDLE;
        if (ctrl_q[2:1] == MODE_AUTO) begin
          flag_d = 1'b0;
        end else begin
          ctrl_d[0] = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (we_i) begin
      case (off_i)
        TMR_OFF_CTRL: begin
          ctrl_d = wdata_i[3:0];
          if (!set_s) begin
            flag_d = 1'b0;
          end else begin
            flag_d = 1'b1;
          end
        end
        TMR_OFF_PRESET: begin
          preset_d = wdata_i;
          if (!set_s) begin
            flag_d = 1'b0;
          end else begin
            flag_d = 1'b1;
          end
        end
        default: begin
          ctrl_d = ctrl_d;
        end
      endcase
    end else begin
      ctrl_d = ctrl_d;
    end
  end

  // Timer state registers; irq is registered from the next-state flag and mask
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ctrl_q   <= 4'd0;
      preset_q <= 32'd0;
      count_q  <= 32'd0;
      flag_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
      irq_q    <= flag_d & ctrl_d[3];
    end
  end

  // Combinational register read-back
  always_comb begin
    case (off_i)
      TMR_OFF_CTRL:   rdata_o = {28'd0, ctrl_q};
      TMR_OFF_PRESET: rdata_o = preset_q;
      TMR_OFF_COUNT:  rdata_o = count_q;
      default:        rdata_o = 32'd0;
    endcase
  end

  assign irq_o = irq_q;

endmodule

// File: rtl/data_bus_responder.sv
// data_bus_responder: data-memory and timer responder for the CPU memory
// stage. Holds the DM array and address decode; the timer lives in timer_dev.
// Optional macro DM_WRITE_LOG_EN prints one console line per DM write.
module data_bus_responder
  import dbus_pkg::*;
#(
  parameter int DM_WORDS = 3072
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_data_addr,
  input  logic [31:0] m_data_wdata,
  input  logic [3:0]  m_data_byteen,
  input  logic [31:0] m_inst_addr,
  output logic [31:0] m_data_rdata,
  output logic        irq
);

  localparam logic [31:0] DM_WORDS_W = 32'(DM_WORDS);

  logic [31:0] dm_q [DM_WORDS];
  logic [11:0] dm_idx_s;
  logic        dm_sel_s;
  logic        dm_we_s;
  logic [31:0] dm_rd_s;
  logic [31:0] dm_merged_s;
  logic        tmr_sel_s;
  logic        tmr_we_s;
  logic [31:0] tmr_rdata_s;

  assign dm_idx_s    = m_data_addr[13:2];
  // Full 32-bit compare so high addresses never alias into DM
  assign dm_sel_s    = (m_data_addr < DM_LIMIT) && ({20'd0, dm_idx_s} < DM_WORDS_W);
  assign dm_we_s     = dm_sel_s && (m_data_byteen != 4'b0000);
  assign dm_rd_s     = dm_q[dm_idx_s];
  assign dm_merged_s = merge_lanes(dm_rd_s, m_data_wdata, m_data_byteen);

  assign tmr_sel_s = (m_data_addr[31:4] == TMR_BASE[31:4]) && (m_data_addr[3:2] != 2'b11);
  // Timer registers only accept full-word stores
  assign tmr_we_s  = tmr_sel_s && (m_data_byteen == 4'b1111);

  // DM storage: async clear, lane-merged write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DM_WORDS; i++) begin
        dm_q[i] <= 32'd0;
      end
    end else if (dm_we_s) begin
      dm_q[dm_idx_s] <= dm_merged_s;
    end
  end

  timer_dev u_timer (
    .clk     (clk),
    .reset   (reset),
    .we_i    (tmr_we_s),
    .off_i   (m_data_addr[3:2]),
    .wdata_i (m_data_wdata),
    .rdata_o (tmr_rdata_s),
    .irq_o   (irq)
  );

  // Read mux: same-cycle read shows the pre-write DM contents
  always_comb begin
    m_data_rdata = 32'd0;
    if (dm_sel_s) begin
      m_data_rdata = dm_rd_s;
    end else if (tmr_sel_s) begin
      m_data_rdata = tmr_rdata_s;
    end else begin
      m_data_rdata = 32'd0;
    end
  end

`ifdef DM_WRITE_LOG_EN
  // Console trace of every DM write with the final merged word
  always_ff @(posedge clk) begin
    if (!reset && dm_we_s) begin
      $display("@%h: *%h <= %h", m_inst_addr, {m_data_addr[31:2], 2'b00}, dm_merged_s);
    end
  end
`else
  logic unused_inst_addr_s;
  assign unused_inst_addr_s = ^m_inst_addr;
`endif

endmodule
